// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer
// Purpose  : Control sequencer for a DSP48A1-style MAC pipeline. Runs an
//            N-sample multiply-accumulate: clears P, accepts operand pairs
//            over valid/ready, tracks each accepted sample through the M and
//            P register stages and pulses done once the final product has
//            been loaded into P.
// Ports    : clk       rising-edge clock
//            rst       asynchronous active-high reset
//            start     begin a run (sampled only in IDLE)
//            len       run length in samples (captured on start)
//            in_valid  operand pair presented on the A/B datapath
//            in_ready  sequencer accepts the operand pair this cycle
//            ce_in     CE for A/B operand registers (= accept)
//            ce_m      CE for M register
//            ce_p      CE for P register
//            rst_p     synchronous clear for P register
//            opmode    OPMODE to the DSP slice
//            busy      high in every state except IDLE
//            done      one-cycle pulse, final result valid on P
//            count     samples accepted in the current/last run
// Revision : 1.0  initial release
// ============================================================================
module dsp_mac_sequencer #(
  parameter int           LEN_WIDTH   = 8,
  parameter int           M_STAGE     = 1,
  parameter int           P_STAGE     = 2,
  parameter logic [7:0]   ACC_OPMODE  = 8'b00001001,
  parameter logic [7:0]   IDLE_OPMODE = 8'b00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ce_in,
  output logic                 ce_m,
  output logic                 ce_p,
  output logic                 rst_p,
  output logic [7:0]           opmode,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [P_STAGE-1:0]    vpipe;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  accept;
  logic                  last_accept;
  logic                  drain_last;

  assign accept      = in_valid & in_ready;
  assign ce_in       = accept;
  assign last_accept = accept && (count == (len_q - LEN_WIDTH'(1)));

  // Sample-tracking shift register: bit k set means a sample accepted k+1
  // cycles ago. The M and P enables are fixed taps of it.
  assign ce_m = vpipe[M_STAGE-1];
  assign ce_p = vpipe[P_STAGE-1];

  // In DRAIN no new samples enter, so once only the top bit can still be set
  // this cycle is the final P load and DONE follows directly. Waiting for the
  // whole pipe to read zero would cost one extra cycle of latency.
  assign drain_last = (vpipe[P_STAGE-2:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[P_STAGE-2:0], accept};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run length and accepted-sample count. A zero-length start still counts
  // as a new run, so count restarts at zero for it as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      count <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        len_q <= len;
        count <= '0;
      end else if (state == S_FEED && accept) begin
        count <= count + LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    rst_p      = 1'b0;
    opmode     = IDLE_OPMODE;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        rst_p      = 1'b1;
        state_next = S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        opmode   = ACC_OPMODE;
        if (last_accept) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        opmode = ACC_OPMODE;
        if (drain_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Purpose  : Self-checking bench for dsp_mac_sequencer. A per-cycle vector
//            table covers the continuous and bubbled runs; short hand-written
//            sequences cover reset, zero-length runs, held start and a reset
//            during DRAIN.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic       ce_in;
  logic       ce_m;
  logic       ce_p;
  logic       rst_p;
  logic [7:0] opmode;
  logic       busy;
  logic       done;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  dsp_mac_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ce_in    (ce_in),
    .ce_m     (ce_m),
    .ce_p     (ce_p),
    .rst_p    (rst_p),
    .opmode   (opmode),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock cycle: inputs applied in that cycle and the outputs
  // expected while they are applied.
  typedef struct {
    logic       start;
    logic [7:0] len;
    logic       in_valid;
    logic       in_ready;
    logic       ce_in;
    logic       ce_m;
    logic       ce_p;
    logic       rst_p;
    logic [7:0] opmode;
    logic       busy;
    logic       done;
    logic [7:0] count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic [7:0] l, input logic v,
                              input logic rdy, input logic ci, input logic cm,
                              input logic cp, input logic rp, input logic [7:0] op,
                              input logic b, input logic d, input logic [7:0] c);
    vec_t r;
    r.start = s;   r.len = l;     r.in_valid = v;
    r.in_ready = rdy; r.ce_in = ci; r.ce_m = cm; r.ce_p = cp;
    r.rst_p = rp;  r.opmode = op; r.busy = b;  r.done = d; r.count = c;
    return r;
  endfunction

  function automatic logic [22:0] outs_now();
    return {in_ready, ce_in, ce_m, ce_p, rst_p, busy, done, opmode, count};
  endfunction

  function automatic logic [22:0] outs_exp(input vec_t r);
    return {r.in_ready, r.ce_in, r.ce_m, r.ce_p, r.rst_p, r.busy, r.done,
            r.opmode, r.count};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge, drive inputs, let combinational
  // outputs settle.
  task automatic cyc(input logic s, input logic [7:0] l, input logic v);
    @(negedge clk);
    start    = s;
    len      = l;
    in_valid = v;
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_outputs", 32'(outs_now()), 32'h0);
    rst = 1'b0;

    // ---------------- vector table ----------------
    // len=4, in_valid held high: accepts in cycles 2..5, done at 8.
    vecs.push_back(mk(1, 4, 1,  0,0,0,0,0, 8'h00, 0,0, 0)); // IDLE
    vecs.push_back(mk(0, 4, 1,  0,0,0,0,1, 8'h00, 1,0, 0)); // CLEAR
    vecs.push_back(mk(0, 4, 1,  1,1,0,0,0, 8'h09, 1,0, 0)); // FEED
    vecs.push_back(mk(0, 4, 1,  1,1,1,0,0, 8'h09, 1,0, 1));
    vecs.push_back(mk(0, 4, 1,  1,1,1,1,0, 8'h09, 1,0, 2));
    vecs.push_back(mk(0, 4, 1,  1,1,1,1,0, 8'h09, 1,0, 3)); // last accept
    vecs.push_back(mk(0, 4, 1,  0,0,1,1,0, 8'h09, 1,0, 4)); // DRAIN
    vecs.push_back(mk(0, 4, 1,  0,0,0,1,0, 8'h09, 1,0, 4)); // DRAIN, last ce_p
    vecs.push_back(mk(0, 4, 1,  0,0,0,0,0, 8'h00, 1,1, 4)); // DONE
    vecs.push_back(mk(0, 4, 0,  0,0,0,0,0, 8'h00, 0,0, 4)); // IDLE
    // len=3 with in_valid pattern 1,0,0,1,0,1 in FEED; done at last accept+3.
    vecs.push_back(mk(1, 3, 0,  0,0,0,0,0, 8'h00, 0,0, 4)); // IDLE, count held
    vecs.push_back(mk(0, 3, 0,  0,0,0,0,1, 8'h00, 1,0, 0)); // CLEAR
    vecs.push_back(mk(0, 3, 1,  1,1,0,0,0, 8'h09, 1,0, 0));
    vecs.push_back(mk(0, 3, 0,  1,0,1,0,0, 8'h09, 1,0, 1));
    vecs.push_back(mk(0, 3, 0,  1,0,0,1,0, 8'h09, 1,0, 1));
    vecs.push_back(mk(0, 3, 1,  1,1,0,0,0, 8'h09, 1,0, 1));
    vecs.push_back(mk(0, 3, 0,  1,0,1,0,0, 8'h09, 1,0, 2));
    vecs.push_back(mk(0, 3, 1,  1,1,0,1,0, 8'h09, 1,0, 2)); // last accept
    vecs.push_back(mk(0, 3, 1,  0,0,1,0,0, 8'h09, 1,0, 3)); // DRAIN
    vecs.push_back(mk(0, 3, 1,  0,0,0,1,0, 8'h09, 1,0, 3)); // DRAIN
    vecs.push_back(mk(0, 3, 0,  0,0,0,0,0, 8'h00, 1,1, 3)); // DONE
    vecs.push_back(mk(0, 3, 0,  0,0,0,0,0, 8'h00, 0,0, 3)); // IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].start, vecs[i].len, vecs[i].in_valid);
      chk($sformatf("vec%0d", i), 32'(outs_now()), 32'(outs_exp(vecs[i])));
    end

    // ---------------- zero-length run ----------------
    cyc(1, 0, 0);
    chk("len0_idle_busy", 32'(busy), 32'd0);
    cyc(0, 0, 0);
    chk("len0_done_cycle", 32'(outs_now()), 32'({7'b0000011, 8'h00, 8'd0}));
    cyc(0, 0, 0);
    chk("len0_back_idle", 32'({busy, done, rst_p}), 32'd0);

    // ---------------- start held through run and done ----------------
    cyc(1, 2, 1);  chk("hold_c0_idle", 32'(busy), 32'd0);
    cyc(1, 2, 1);  chk("hold_c1_clear", 32'(rst_p), 32'd1);
    cyc(1, 2, 1);  chk("hold_c2_feed", 32'({in_ready, count}), 32'({1'b1, 8'd0}));
    cyc(1, 2, 1);  chk("hold_c3_feed", 32'({in_ready, count}), 32'({1'b1, 8'd1}));
    cyc(1, 2, 1);  chk("hold_c4_drain", 32'({in_ready, rst_p, count}), 32'({2'b00, 8'd2}));
    cyc(1, 2, 1);  chk("hold_c5_drain", 32'({ce_p, done}), 32'({1'b1, 1'b0}));
    cyc(1, 2, 1);  chk("hold_c6_done", 32'({done, busy, rst_p}), 32'({3'b110}));
    cyc(1, 2, 1);  chk("hold_c7_idle", 32'({busy, done, count}), 32'({2'b00, 8'd2}));
    cyc(0, 2, 1);  chk("hold_c8_clear", 32'({rst_p, busy, count}), 32'({2'b11, 8'd0}));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(0, 2, 1);
      if (done) seen = 1'b1;
    end
    chk("hold_second_run_done", 32'(seen), 32'd1);

    // ---------------- reset during DRAIN ----------------
    cyc(1, 2, 1);
    cyc(0, 2, 1);
    cyc(0, 2, 1);
    cyc(0, 2, 1);
    cyc(0, 2, 1);
    chk("rst_drain_pre", 32'({ce_m, ce_p, opmode}), 32'({2'b11, 8'h09}));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'(outs_now()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2, 1);
      if (ce_p || done || busy) seen = 1'b1;
    end
    chk("rst_no_ce_p_done", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
